alu_seq_ctrl: RTL and testbench
===============================

# alu_seq_ctrl

Sequencing front-end for the N-bit ALU: accepts one operation per valid/ready handshake (operands plus the 4-bit op code used by the ALU result mux), computes every op class, and returns one registered result with status flags over a second valid/ready handshake. Single-cycle ops complete in one cycle. Divide and modulo run on an iterative restoring divider. The block sits between the instruction/control path and the register-file write-back.

## Interface
- `N`, default 4: operand/result width; N ≥ 2.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: request present.
- `in_ready` output 1: block can accept a request.
- `a` input N: operand A.
- `b` input N: operand B.
- `op` input 4: op code. 0000 sum, 0001 sub, 0010 mul, 0011 div, 0100 mod, 1000 or, 1001 and, 1010 xor, 1011 shift left, 1100 shift right. All other codes are reserved.
- `out_valid` output 1: result present.
- `out_ready` input 1: consumer accepts the result.
- `result` output N: registered result.
- `zero`, `negative`, `carry`, `overflow` output 1 each: registered flags.
- `err` output 1: reserved op or divide-by-zero.

## Operation
- States: IDLE, DIV, DONE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid` & `in_ready`, capture `a`, `b`, `op`.
  - Div/mod with `b` ≠ 0 → DIV.
  - Every other op computes its result, registers it with flags, and goes → DONE.
- **DIV**
  - Runs N restoring iterations, one per cycle.
  - Then registers the quotient (div) or remainder (mod) → DONE.
- **DONE**
  - `out_valid` = 1.
  - `result` and flags are held stable until `out_ready` = 1 → IDLE.
- `in_ready` is 0 in DIV and DONE. There is no overlap between accepting a new request and holding a pending result.
- **Arithmetic** (all results truncated to N bits):
  - sum: `carry` = carry-out; `overflow` = signed overflow.
  - sub: computes a − b. `carry` = borrow (a < b unsigned); `overflow` = signed overflow.
  - mul: unsigned, low N bits. `carry` = 1 when the upper N bits of the 2N-bit product are nonzero.
  - Shifts are logical by `b`. If b ≥ N, result = 0.
  - `carry` and `overflow` are 0 for all ops not listed above.
  - `zero` = (result == 0) and `negative` = result[N−1] for every op.
- **Divide-by-zero:** div returns all ones and mod returns `a`. Both set `err` = 1, complete in one cycle, and do not enter DIV.
- **Reserved op:** result = 0, `zero` = 1, `err` = 1.
- **Reset:** asynchronous assertion at any time, including mid-DIV, aborts the operation. The in-flight result is discarded.
- **Reset values:**
  - state = IDLE, so `in_ready` = 1.
  - `out_valid` = 0.
  - `result` = 0.
  - `zero`, `negative`, `carry`, `overflow`, `err` = 0.

## Timing
- Single-cycle ops and error cases: request accepted at edge t, `out_valid` = 1 after edge t+1.
- Div/mod: `out_valid` = 1 after edge t+1+N (4-bit: 5 cycles).
- Result-to-next-accept:
  - If `out_ready` is already 1 when `out_valid` rises, `in_ready` returns 1 in the next cycle.
  - The minimum request-to-request spacing is 2 cycles.
- `out_ready` is ignored while `out_valid` = 0.
- `in_valid` is ignored while `in_ready` = 0.
- `in_ready` and `out_valid` are decoded from registered state only. There is no combinational path from any input to any output.

## Configuration
- `ALU_SEQ_DIV_EN` defined:
  - The divider and DIV state are built.
  - Div/mod behave as specified above.
- `ALU_SEQ_DIV_EN` undefined:
  - The divider and DIV state are removed.
  - 0011 and 0100 are treated as reserved ops: result 0, `err` = 1, one-cycle latency.

## Structure
- Shared package `alu_pkg`:
  - `alu_op_e` enum: 4-bit op codes, including reserved codes.
  - `alu_state_e` enum: IDLE/DIV/DONE.
  - Flag struct type.
- Sub-module `alu_divider`:
  - Iterative restoring N-bit unsigned divider.
  - start/busy/done interface; outputs quotient and remainder.
  - Compiled under `ALU_SEQ_DIV_EN`.
- Single-cycle datapath is inline in `alu_seq_ctrl`.

## Test plan (N = 4)
- **Sum:** a = 7, b = 9 → result 0, `zero` = 1, `carry` = 1, `overflow` = 0, `out_valid` one cycle after accept.
- **Sub:** a = 3, b = 5 → result 4'hE, `negative` = 1, `carry` = 1, `overflow` = 0.
- **Div/mod:** 13 div 4 → 3 with `out_valid` exactly 5 cycles after accept; 13 mod 4 → 1; 4'hF × 2 → 4'hE with `carry` = 1.
- **Divide-by-zero:** div with b = 0 → 4'hF with `err` = 1 after 1 cycle; mod with a = 6, b = 0 → 6 with `err` = 1.
- **Reserved op:** op 0110 → result 0, `zero` = 1, `err` = 1. Rebuilt without `ALU_SEQ_DIV_EN`: op 0011 → result 0, `err` = 1 after 1 cycle.
- **Backpressure and reset:**
  - Hold `out_ready` = 0 for 3 cycles → `result`/flags stable and `in_ready` = 0 throughout.
  - Assert `rst_n` low mid-DIV → `out_valid` = 0 and all outputs at reset values immediately.
  - After reset release, `in_ready` = 1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes, sequencer states and flag bundle for the ALU front-end.
package alu_pkg;

   // Op codes as seen on the ALU result mux; unnamed slots are reserved.
   typedef enum logic [3:0] {
      OP_SUM  = 4'b0000,
      OP_SUB  = 4'b0001,
      OP_MUL  = 4'b0010,
      OP_DIV  = 4'b0011,
      OP_MOD  = 4'b0100,
      OP_RSV5 = 4'b0101,
      OP_RSV6 = 4'b0110,
      OP_RSV7 = 4'b0111,
      OP_OR   = 4'b1000,
      OP_AND  = 4'b1001,
      OP_XOR  = 4'b1010,
      OP_SHL  = 4'b1011,
      OP_SHR  = 4'b1100,
      OP_RSVD = 4'b1101,
      OP_RSVE = 4'b1110,
      OP_RSVF = 4'b1111
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIV  = 2'd1,
      ST_DONE = 2'd2
   } alu_state_e;

   typedef struct packed {
      logic zero;
      logic negative;
      logic carry;
      logic overflow;
      logic err;
   } alu_flags_t;

   localparam alu_flags_t FLAGS_CLEAR = '0;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl_if: request handshake (operands/op) and result handshake (result/flags).
interface alu_seq_ctrl_if #(parameter int N = 4) ();

   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic [3:0]   op;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] result;
   logic         zero;
   logic         negative;
   logic         carry;
   logic         overflow;
   logic         err;

   // Requester / result consumer side.
   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, result, zero, negative, carry, overflow, err
   );

   // Sequencer side.
   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, result, zero, negative, carry, overflow, err
   );

endinterface

// File: rtl/alu_divider.sv
// alu_divider: iterative restoring unsigned divider, one quotient bit per cycle.
// Only built when ALU_SEQ_DIV_EN is defined. The first iteration runs on the
// start cycle straight from the operand inputs, so done pulses N-1 cycles later.
`ifdef ALU_SEQ_DIV_EN
module alu_divider #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder
);

   localparam int CW = $clog2(N);

   logic [N-1:0]  rem_reg, quo_reg, dvs_reg;
   logic [CW-1:0] cnt_reg;
   logic          busy_reg, done_reg;

   logic [N-1:0]  src_rem, src_quo, src_dvs;
   logic [N-1:0]  step_rem, step_quo;
   logic [N:0]    shifted, trial;

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      src_rem = start ? '0       : rem_reg;
      src_quo = start ? dividend : quo_reg;
      src_dvs = start ? divisor  : dvs_reg;
      shifted = {src_rem, src_quo[N-1]};
      trial   = shifted - {1'b0, src_dvs};
      if (trial[N]) begin
         step_rem = shifted[N-1:0];
         step_quo = {src_quo[N-2:0], 1'b0};
      end else begin
         step_rem = trial[N-1:0];
         step_quo = {src_quo[N-2:0], 1'b1};
      end
   end

   // Iteration counter and partial remainder/quotient registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_reg  <= '0;
         quo_reg  <= '0;
         dvs_reg  <= '0;
         cnt_reg  <= '0;
         busy_reg <= 1'b0;
         done_reg <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (start) begin
            rem_reg  <= step_rem;
            quo_reg  <= step_quo;
            dvs_reg  <= divisor;
            cnt_reg  <= CW'(1);
            busy_reg <= 1'b1;
         end else if (busy_reg) begin
            rem_reg <= step_rem;
            quo_reg <= step_quo;
            cnt_reg <= cnt_reg + CW'(1);
            if (cnt_reg == CW'(N-1)) begin
               busy_reg <= 1'b0;
               done_reg <= 1'b1;
            end
         end
      end
   end

   assign busy      = busy_reg;
   assign done      = done_reg;
   assign quotient  = quo_reg;
   assign remainder = rem_reg;

endmodule
`endif

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: one-request-at-a-time ALU sequencer with registered result/flags.
// ALU_SEQ_DIV_EN builds the iterative divider for div/mod; without it those
// codes complete in one cycle as reserved ops.
module alu_seq_ctrl
   import alu_pkg::*;
#(
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   alu_seq_ctrl_if.slave  bus
);

   localparam logic [N-1:0] N_VAL = N'(N);

   alu_state_e   state_reg, state_next;
   logic [N-1:0] result_reg;
   alu_flags_t   flags_reg;

   logic [N-1:0]   sc_result;
   alu_flags_t     sc_flags;
   logic [N:0]     sum_ext, sub_ext;
   logic [2*N-1:0] mul_full;
   logic           accept;
   logic           div_start;

   assign accept = (state_reg == ST_IDLE) && bus.in_valid;

`ifdef ALU_SEQ_DIV_EN
   logic         op_mod_reg;
   logic         div_busy, div_done;
   logic [N-1:0] div_quo, div_rem, div_result;
   alu_flags_t   div_flags;

   // Only a nonzero divisor goes to the iterative divider.
   assign div_start = accept && (bus.op == OP_DIV || bus.op == OP_MOD) && (bus.b != '0);

   alu_divider #(.N(N)) u_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (div_start),
      .dividend  (bus.a),
      .divisor   (bus.b),
      .busy      (div_busy),
      .done      (div_done),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   // Remember whether the in-flight divide wants the quotient or the remainder.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         op_mod_reg <= 1'b0;
      else if (div_start) op_mod_reg <= (bus.op == OP_MOD);
   end

   // Divider result selection and its flags (carry/overflow/err never set).
   always_comb begin
      div_result         = op_mod_reg ? div_rem : div_quo;
      div_flags          = FLAGS_CLEAR;
      div_flags.zero     = (div_result == '0);
      div_flags.negative = div_result[N-1];
   end
`else
   assign div_start = 1'b0;
`endif

   // Single-cycle datapath, evaluated on the request operands.
   always_comb begin
      sum_ext   = {1'b0, bus.a} + {1'b0, bus.b};
      sub_ext   = {1'b0, bus.a} - {1'b0, bus.b};
      mul_full  = {{N{1'b0}}, bus.a} * {{N{1'b0}}, bus.b};
      sc_result = '0;
      sc_flags  = FLAGS_CLEAR;
      case (alu_op_e'(bus.op))
         OP_SUM: begin
            sc_result         = sum_ext[N-1:0];
            sc_flags.carry    = sum_ext[N];
            sc_flags.overflow = (bus.a[N-1] == bus.b[N-1]) && (sum_ext[N-1] != bus.a[N-1]);
         end
         OP_SUB: begin
            sc_result         = sub_ext[N-1:0];
            sc_flags.carry    = sub_ext[N];
            sc_flags.overflow = (bus.a[N-1] != bus.b[N-1]) && (sub_ext[N-1] != bus.a[N-1]);
         end
         OP_MUL: begin
            sc_result      = mul_full[N-1:0];
            sc_flags.carry = (mul_full[2*N-1:N] != '0);
         end
`ifdef ALU_SEQ_DIV_EN
         // Reaching here means divide-by-zero; nonzero divisors go to the divider.
         OP_DIV: begin
            sc_result    = '1;
            sc_flags.err = 1'b1;
         end
         OP_MOD: begin
            sc_result    = bus.a;
            sc_flags.err = 1'b1;
         end
`endif
         OP_OR:  sc_result = bus.a | bus.b;
         OP_AND: sc_result = bus.a & bus.b;
         OP_XOR: sc_result = bus.a ^ bus.b;
         OP_SHL: sc_result = (bus.b >= N_VAL) ? '0 : (bus.a << bus.b);
         OP_SHR: sc_result = (bus.b >= N_VAL) ? '0 : (bus.a >> bus.b);
         default: sc_flags.err = 1'b1;
      endcase
      sc_flags.zero     = (sc_result == '0);
      sc_flags.negative = sc_result[N-1];
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= ST_IDLE;
      else        state_reg <= state_next;
   end

   // Next-state decode.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (bus.in_valid) state_next = div_start ? ST_DIV : ST_DONE;
         ST_DIV: begin
`ifdef ALU_SEQ_DIV_EN
            if (div_done)       state_next = ST_DONE;
            else if (!div_busy) state_next = ST_IDLE;
`else
            state_next = ST_IDLE;
`endif
         end
         ST_DONE: if (bus.out_ready) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Result and flag registers: loaded on a single-cycle accept or divider completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_reg <= '0;
         flags_reg  <= FLAGS_CLEAR;
      end else if (accept && !div_start) begin
         result_reg <= sc_result;
         flags_reg  <= sc_flags;
      end
`ifdef ALU_SEQ_DIV_EN
      else if ((state_reg == ST_DIV) && div_done) begin
         result_reg <= div_result;
         flags_reg  <= div_flags;
      end
`endif
   end

   // Outputs come only from registered state.
   always_comb begin
      bus.in_ready  = (state_reg == ST_IDLE);
      bus.out_valid = (state_reg == ST_DONE);
      bus.result    = result_reg;
      bus.zero      = flags_reg.zero;
      bus.negative  = flags_reg.negative;
      bus.carry     = flags_reg.carry;
      bus.overflow  = flags_reg.overflow;
      bus.err       = flags_reg.err;
   end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed-vector bench for the ALU sequencer, N = 4.
// Expectations follow the ALU_SEQ_DIV_EN setting of the build.
module tb_alu_seq_ctrl;

   localparam int N = 4;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] op;
      logic [3:0] res;
      logic [4:0] fl;   // {zero, negative, carry, overflow, err}
      int         lat;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   tests_run = 0;
   int   tests_failed = 0;

   alu_seq_ctrl_if #(.N(N)) bus ();

   alu_seq_ctrl #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] flags();
      return {bus.zero, bus.negative, bus.carry, bus.overflow, bus.err};
   endfunction

   // Present one request at a negedge; return cycles until out_valid (-1 on timeout).
   task automatic send(input logic [3:0] aa, input logic [3:0] bb, input logic [3:0] oo,
                       output int lat);
      bus.a = aa; bus.b = bb; bus.op = oo; bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         if (bus.out_valid === 1'b1) begin
            lat = i;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      bus.a = '0; bus.b = '0; bus.op = '0;
      #2 rst_n = 1'b0;
      #1;
      $display("[TB] reset in_ready=%b out_valid=%b result=%h flags=%b",
               bus.in_ready, bus.out_valid, bus.result, flags());
      tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
      tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
      tests_run++; if (bus.result !== 4'h0) begin tests_failed++; $display("FAIL reset_result: got %h expected 0", bus.result); end
      tests_run++; if (flags() !== 5'b00000) begin tests_failed++; $display("FAIL reset_flags: got %b expected 00000", flags()); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_arith();
      vec_t v [9];
      int   lat;
      v = '{'{4'h7, 4'h9, 4'h0, 4'h0, 5'b10100, 1},   // sum wraps to zero with carry
            '{4'h7, 4'h1, 4'h0, 4'h8, 5'b01010, 1},   // signed overflow
            '{4'h5, 4'h2, 4'h0, 4'h7, 5'b00000, 1},
            '{4'h3, 4'h5, 4'h1, 4'hE, 5'b01100, 1},   // borrow
            '{4'h8, 4'h1, 4'h1, 4'h7, 5'b00010, 1},   // -8 - 1 overflows
            '{4'h6, 4'h6, 4'h1, 4'h0, 5'b10000, 1},
            '{4'hF, 4'h2, 4'h2, 4'hE, 5'b01100, 1},   // product 0x1E
            '{4'h3, 4'h5, 4'h2, 4'hF, 5'b01000, 1},
            '{4'h0, 4'h9, 4'h2, 4'h0, 5'b10000, 1}};
      for (int i = 0; i < 9; i++) begin
         send(v[i].a, v[i].b, v[i].op, lat);
         $display("[TB] arith a=%h b=%h op=%h -> result=%h flags=%b lat=%0d",
                  v[i].a, v[i].b, v[i].op, bus.result, flags(), lat);
         tests_run++; if (lat != v[i].lat) begin tests_failed++; $display("FAIL arith_lat[%0d]: got %0d expected %0d", i, lat, v[i].lat); end
         tests_run++; if (bus.result !== v[i].res) begin tests_failed++; $display("FAIL arith_result[%0d]: got %h expected %h", i, bus.result, v[i].res); end
         tests_run++; if (flags() !== v[i].fl) begin tests_failed++; $display("FAIL arith_flags[%0d]: got %b expected %b", i, flags(), v[i].fl); end
         @(negedge clk);
      end
   endtask

   task automatic test_logic_shift();
      vec_t v [8];
      int   lat;
      v = '{'{4'hC, 4'h3, 4'h8, 4'hF, 5'b01000, 1},
            '{4'hC, 4'hA, 4'h9, 4'h8, 5'b01000, 1},
            '{4'hC, 4'hA, 4'hA, 4'h6, 5'b00000, 1},
            '{4'h3, 4'h2, 4'hB, 4'hC, 5'b01000, 1},
            '{4'hC, 4'h3, 4'hC, 4'h1, 5'b00000, 1},
            '{4'h1, 4'h4, 4'hB, 4'h0, 5'b10000, 1},   // shift by N
            '{4'hF, 4'hF, 4'hC, 4'h0, 5'b10000, 1},   // shift beyond N
            '{4'hF, 4'h3, 4'hC, 4'h1, 5'b00000, 1}};
      for (int i = 0; i < 8; i++) begin
         send(v[i].a, v[i].b, v[i].op, lat);
         $display("[TB] logic a=%h b=%h op=%h -> result=%h flags=%b lat=%0d",
                  v[i].a, v[i].b, v[i].op, bus.result, flags(), lat);
         tests_run++; if (lat != v[i].lat) begin tests_failed++; $display("FAIL logic_lat[%0d]: got %0d expected %0d", i, lat, v[i].lat); end
         tests_run++; if (bus.result !== v[i].res) begin tests_failed++; $display("FAIL logic_result[%0d]: got %h expected %h", i, bus.result, v[i].res); end
         tests_run++; if (flags() !== v[i].fl) begin tests_failed++; $display("FAIL logic_flags[%0d]: got %b expected %b", i, flags(), v[i].fl); end
         @(negedge clk);
      end
   endtask

   task automatic test_div();
      vec_t v [7];
      int   lat;
`ifdef ALU_SEQ_DIV_EN
      v = '{'{4'hD, 4'h4, 4'h3, 4'h3, 5'b00000, 5},
            '{4'hD, 4'h4, 4'h4, 4'h1, 5'b00000, 5},
            '{4'hF, 4'hF, 4'h3, 4'h1, 5'b00000, 5},
            '{4'hE, 4'h3, 4'h4, 4'h2, 5'b00000, 5},
            '{4'h9, 4'hA, 4'h3, 4'h0, 5'b10000, 5},
            '{4'h5, 4'h0, 4'h3, 4'hF, 5'b01001, 1},   // divide-by-zero
            '{4'h6, 4'h0, 4'h4, 4'h6, 5'b00001, 1}};
`else
      v = '{'{4'hD, 4'h4, 4'h3, 4'h0, 5'b10001, 1},   // div/mod reserved without the divider
            '{4'hD, 4'h4, 4'h4, 4'h0, 5'b10001, 1},
            '{4'hF, 4'hF, 4'h3, 4'h0, 5'b10001, 1},
            '{4'hE, 4'h3, 4'h4, 4'h0, 5'b10001, 1},
            '{4'h9, 4'hA, 4'h3, 4'h0, 5'b10001, 1},
            '{4'h5, 4'h0, 4'h3, 4'h0, 5'b10001, 1},
            '{4'h6, 4'h0, 4'h4, 4'h0, 5'b10001, 1}};
`endif
      for (int i = 0; i < 7; i++) begin
         send(v[i].a, v[i].b, v[i].op, lat);
         $display("[TB] div a=%h b=%h op=%h -> result=%h flags=%b lat=%0d",
                  v[i].a, v[i].b, v[i].op, bus.result, flags(), lat);
         tests_run++; if (lat != v[i].lat) begin tests_failed++; $display("FAIL div_lat[%0d]: got %0d expected %0d", i, lat, v[i].lat); end
         tests_run++; if (bus.result !== v[i].res) begin tests_failed++; $display("FAIL div_result[%0d]: got %h expected %h", i, bus.result, v[i].res); end
         tests_run++; if (flags() !== v[i].fl) begin tests_failed++; $display("FAIL div_flags[%0d]: got %b expected %b", i, flags(), v[i].fl); end
         @(negedge clk);
      end
   endtask

   task automatic test_reserved();
      logic [3:0] ops [4];
      int         lat;
      ops = '{4'h6, 4'hF, 4'h5, 4'hD};
      for (int i = 0; i < 4; i++) begin
         send(4'h3, 4'h3, ops[i], lat);
         $display("[TB] reserved op=%h -> result=%h flags=%b lat=%0d", ops[i], bus.result, flags(), lat);
         tests_run++; if (lat != 1) begin tests_failed++; $display("FAIL rsv_lat[%0d]: got %0d expected 1", i, lat); end
         tests_run++; if (bus.result !== 4'h0) begin tests_failed++; $display("FAIL rsv_result[%0d]: got %h expected 0", i, bus.result); end
         tests_run++; if (flags() !== 5'b10001) begin tests_failed++; $display("FAIL rsv_flags[%0d]: got %b expected 10001", i, flags()); end
         @(negedge clk);
      end
   endtask

   task automatic test_backpressure();
      int lat;
      bus.out_ready = 1'b0;
      send(4'h2, 4'h3, 4'h0, lat);
      tests_run++; if (lat != 1) begin tests_failed++; $display("FAIL bp_lat: got %0d expected 1", lat); end
      for (int i = 0; i < 3; i++) begin
         bus.a = 4'hF; bus.b = 4'hF; bus.op = 4'h2; bus.in_valid = 1'b1;   // must be ignored
         @(negedge clk);
         $display("[TB] hold cycle %0d out_valid=%b in_ready=%b result=%h flags=%b",
                  i, bus.out_valid, bus.in_ready, bus.result, flags());
         tests_run++; if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_out_valid[%0d]: got %b expected 1", i, bus.out_valid); end
         tests_run++; if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, bus.in_ready); end
         tests_run++; if (bus.result !== 4'h5) begin tests_failed++; $display("FAIL bp_result[%0d]: got %h expected 5", i, bus.result); end
         tests_run++; if (flags() !== 5'b00000) begin tests_failed++; $display("FAIL bp_flags[%0d]: got %b expected 00000", i, flags()); end
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      $display("[TB] release out_valid=%b in_ready=%b", bus.out_valid, bus.in_ready);
      tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_release_valid: got %b expected 0", bus.out_valid); end
      tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_release_ready: got %b expected 1", bus.in_ready); end
   endtask

   task automatic test_back_to_back();
      int lat;
      send(4'h1, 4'h2, 4'h0, lat);
      $display("[TB] b2b first result=%h lat=%0d in_ready=%b", bus.result, lat, bus.in_ready);
      tests_run++; if (bus.result !== 4'h3) begin tests_failed++; $display("FAIL b2b_first: got %h expected 3", bus.result); end
      tests_run++; if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_busy: got %b expected 0", bus.in_ready); end
      @(negedge clk);
      tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready: got %b expected 1", bus.in_ready); end
      send(4'h4, 4'h4, 4'h2, lat);
      $display("[TB] b2b second result=%h flags=%b lat=%0d", bus.result, flags(), lat);
      tests_run++; if (lat != 1) begin tests_failed++; $display("FAIL b2b_lat: got %0d expected 1", lat); end
      tests_run++; if ({bus.result, flags()} !== {4'h0, 5'b10100}) begin tests_failed++; $display("FAIL b2b_second: got %h/%b expected 0/10100", bus.result, flags()); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_op();
      int lat;
      // Reset while a result is held pending.
      bus.out_ready = 1'b0;
      send(4'h2, 4'h3, 4'h0, lat);
      #2 rst_n = 1'b0;
      #1;
      $display("[TB] reset in DONE out_valid=%b in_ready=%b result=%h flags=%b",
               bus.out_valid, bus.in_ready, bus.result, flags());
      tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_done_valid: got %b expected 0", bus.out_valid); end
      tests_run++; if ({bus.in_ready, bus.result, flags()} !== {1'b1, 4'h0, 5'b00000}) begin tests_failed++; $display("FAIL rst_done_outputs: got %b/%h/%b expected 1/0/00000", bus.in_ready, bus.result, flags()); end
      @(negedge clk);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);
`ifdef ALU_SEQ_DIV_EN
      // Leave a nonzero result behind, then abort a divide part-way through.
      send(4'h7, 4'h0, 4'h0, lat);
      @(negedge clk);
      bus.a = 4'hD; bus.b = 4'h4; bus.op = 4'h3; bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      $display("[TB] reset mid-DIV out_valid=%b in_ready=%b result=%h flags=%b",
               bus.out_valid, bus.in_ready, bus.result, flags());
      tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_div_valid: got %b expected 0", bus.out_valid); end
      tests_run++; if ({bus.in_ready, bus.result, flags()} !== {1'b1, 4'h0, 5'b00000}) begin tests_failed++; $display("FAIL rst_div_outputs: got %b/%h/%b expected 1/0/00000", bus.in_ready, bus.result, flags()); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_div_stale[%0d]: got %b expected 0", i, bus.out_valid); end
      end
`endif
      tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_release_ready: got %b expected 1", bus.in_ready); end
      send(4'h1, 4'h1, 4'h0, lat);
      $display("[TB] after reset result=%h lat=%0d", bus.result, lat);
      tests_run++; if (lat != 1 || bus.result !== 4'h2) begin tests_failed++; $display("FAIL rst_after_op: got %h lat %0d expected 2 lat 1", bus.result, lat); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_arith();
      test_logic_shift();
      test_div();
      test_reserved();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_op();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
